// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding, default operand width and the iteration-counter width helper.
package div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int W_DEF = 4;

  // Bits needed to hold a count of 0..n-1 (never less than one bit).
  function automatic int clog2(input int n);
    int v;
    v = 1;
    while ((1 << v) < n) v++;
    return v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor if it fits. The compare/subtract is
// W+1 bits wide so the shifted remainder never truncates.
module div_step #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_r,
  input  logic         i_bit,
  input  logic [W-1:0] i_y,
  output logic [W-1:0] o_r,
  output logic         o_q
);

  logic [W:0] w_t;
  logic [W:0] w_sel;
  logic       w_unused_msb;

  assign w_t   = {i_r, i_bit};
  assign o_q   = (w_t >= {1'b0, i_y});
  assign w_sel = o_q ? (w_t - {1'b0, i_y}) : w_t;
  // The kept remainder is always below the divisor, so its MSB is zero.
  assign o_r          = w_sel[W-1:0];
  assign w_unused_msb = w_sel[W];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2W-bit dividend x, W-bit divisor y, one
// quotient bit per clock, valid/ready on both sides. Divide-by-zero and
// quotient overflow finish in one cycle with q all ones and r zero.
// Optional macro SEQ_DIVIDER_SELFCHECK_EN adds a sticky q*y+r == x check.
module seq_divider
  import div_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] x,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           dz,
  output logic           ovf,
  output logic           chk_err
);

  localparam int CW = clog2(W);

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_y;
  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_d;
  logic [W-1:0]   r_q;
  logic [CW-1:0]  r_cnt;
  logic           r_dz;
  logic           r_ovf;
  logic           w_accept;
  logic [W-1:0]   w_x_hi;
  logic           w_is_dz;
  logic           w_is_ovf;
  logic [W-1:0]   w_step_r;
  logic           w_step_q;

  assign w_x_hi   = x[2*W-1:W];
  assign w_is_dz  = (y == '0);
  assign w_is_ovf = (w_x_hi >= y);

  div_step #(.W(W)) u_step (
    .i_r   (r_rem),
    .i_bit (r_d[W-1]),
    .i_y   (r_y),
    .o_r   (w_step_r),
    .o_q   (w_step_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs; handshakes depend on state only.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = (w_is_dz || w_is_ovf) ? DONE : RUN;
        end
      end
      RUN: begin
        if (r_cnt == '0) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture on accept, then one restoring step per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      r_rem <= '0;
      r_dz  <= 1'b0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_y   <= y;
      r_d   <= x[W-1:0];
      r_cnt <= CW'(W-1);
      if (w_is_dz) begin
        r_dz  <= 1'b1;
        r_ovf <= 1'b0;
        r_q   <= '1;
        r_rem <= '0;
      end else if (w_is_ovf) begin
        r_dz  <= 1'b0;
        r_ovf <= 1'b1;
        r_q   <= '1;
        r_rem <= '0;
      end else begin
        r_dz  <= 1'b0;
        r_ovf <= 1'b0;
        r_rem <= w_x_hi;
      end
    end else if (r_state == RUN) begin
      r_rem <= w_step_r;
      r_q   <= {r_q[W-2:0], w_step_q};
      r_d   <= {r_d[W-2:0], 1'b0};
      if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
    end
  end

  assign q   = r_q;
  assign r   = r_rem;
  assign dz  = r_dz;
  assign ovf = r_ovf;

`ifdef SEQ_DIVIDER_SELFCHECK_EN
  logic [2*W-1:0] r_x;
  logic [2*W-1:0] w_recon;
  logic           r_chk_err;

  assign w_recon = ({{W{1'b0}}, r_q} * {{W{1'b0}}, r_y}) + {{W{1'b0}}, r_rem};

  // Keep the full dividend for reconstruction.
  always_ff @(posedge clk) begin
    if (w_accept) r_x <= x;
  end

  // Sticky flag: a non-flagged result that does not rebuild the dividend.
  always_ff @(posedge clk) begin
    if (rst) r_chk_err <= 1'b0;
    else if ((r_state == DONE) && !r_dz && !r_ovf && (w_recon != r_x))
      r_chk_err <= 1'b1;
  end

  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider (W=4): expected results are queued when operands
// are accepted and popped when the divider presents a result.
module tb_seq_divider;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] x;
  logic [W-1:0]   y;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   q;
  logic [W-1:0]   r;
  logic           dz;
  logic           ovf;
  logic           chk_err;

  int   checks;
  int   failures;
  exp_t sb[$];

  seq_divider #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .dz        (dz),
    .ovf       (ovf),
    .chk_err   (chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [2*W-1:0] ax, input logic [W-1:0] ay);
    exp_t e;
    int   xi;
    int   yi;
    xi = int'(ax);
    yi = int'(ay);
    e.dz  = 1'b0;
    e.ovf = 1'b0;
    if (yi == 0) begin
      e.dz = 1'b1;
      e.q  = '1;
      e.r  = '0;
    end else if ((xi >> W) >= yi) begin
      e.ovf = 1'b1;
      e.q   = '1;
      e.r   = '0;
    end else begin
      e.q = W'(xi / yi);
      e.r = W'(xi % yi);
    end
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (q !== '0) begin failures++; $display("FAIL reset_q got=%0d want=0", q); end
    checks++; if (r !== '0) begin failures++; $display("FAIL reset_r got=%0d want=0", r); end
    checks++; if (dz !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b want=0", dz); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    checks++; if (chk_err !== 1'b0) begin failures++; $display("FAIL reset_chk_err got=%b want=0", chk_err); end
  endtask

  // One full transaction: accept, measure latency, compare, retire.
  task automatic test_op(input logic [2*W-1:0] ax, input logic [W-1:0] ay, input string name);
    exp_t e;
    exp_t got;
    int   lat;
    int   exp_lat;
    e       = model(ax, ay);
    exp_lat = (e.dz || e.ovf) ? 1 : W + 1;
    lat = 0;
    while (!in_ready && lat < 50) begin tick(); lat++; end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL %s_in_ready_wait got=%b want=1", name, in_ready);
    end
    in_valid = 1'b1;
    x        = ax;
    y        = ay;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    checks++;
    if (lat != exp_lat) begin
      failures++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, exp_lat);
    end
    if (out_valid && sb.size() > 0) begin
      e   = sb.pop_front();
      got = {q, r, dz, ovf};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s_result got q=%0d r=%0d dz=%b ovf=%b want q=%0d r=%0d dz=%b ovf=%b",
                 name, got.q, got.r, got.dz, got.ovf, e.q, e.r, e.dz, e.ovf);
      end
      checks++;
      if (chk_err !== 1'b0) begin failures++; $display("FAIL %s_chk_err got=%b want=0", name, chk_err); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end else begin
      checks++; failures++;
      $display("FAIL %s_no_result got out_valid=%b queued=%0d want out_valid=1", name, out_valid, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t got;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x = 8'd200;
    y = 4'd15;
    sb.push_back(model(8'd200, 4'd15));
    tick();
    // Next operands presented immediately and held until accepted.
    x = 8'd225;
    y = 4'd15;
    for (int i = 1; i <= W; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        failures++; $display("FAIL b2b_run1_c%0d got in_ready=%b out_valid=%b want 0 0", i, in_ready, out_valid);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_done1 got out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front(); got = {q, r, dz, ovf};
      checks++;
      if (got !== e) begin
        failures++; $display("FAIL b2b_result1 got q=%0d r=%0d dz=%b ovf=%b want q=%0d r=%0d", got.q, got.r, got.dz, got.ovf, e.q, e.r);
      end
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_idle got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    sb.push_back(model(8'd225, 4'd15));
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= W; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        failures++; $display("FAIL b2b_run2_c%0d got in_ready=%b out_valid=%b want 0 0", i, in_ready, out_valid);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_done2 got out_valid=%b want 1", out_valid); end
    if (sb.size() > 0) begin
      e = sb.pop_front(); got = {q, r, dz, ovf};
      checks++;
      if (got !== e) begin
        failures++; $display("FAIL b2b_result2 got q=%0d r=%0d dz=%b ovf=%b want q=%0d r=%0d", got.q, got.r, got.dz, got.ovf, e.q, e.r);
      end
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    in_valid = 1'b1;
    x = 8'd37;
    y = 4'd5;
    sb.push_back(model(8'd37, 4'd5));
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    checks++;
    if (lat != W + 1) begin failures++; $display("FAIL bp_latency got=%0d want=%0d", lat, W + 1); end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    // Offer a divide-by-zero operation while stalled; it must be ignored.
    in_valid = 1'b1;
    x = 8'd99;
    y = 4'd0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || q !== e.q || r !== e.r || dz !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_c%0d got out_valid=%b in_ready=%b q=%0d r=%0d dz=%b want 1 0 q=%0d r=%0d dz=0",
                 i, out_valid, in_ready, q, r, dz, e.q, e.r);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_no_ghost got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    in_valid = 1'b1;
    x = 8'd37;
    y = 4'd5;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== '0) begin
      failures++; $display("FAIL midrst got in_ready=%b out_valid=%b q=%0d want 1 0 0", in_ready, out_valid, q);
    end
    test_op(8'd37, 4'd5, "after_rst");
  endtask

  task automatic test_random();
    logic [2*W-1:0] ax;
    logic [W-1:0]   ay;
    for (int i = 0; i < 12; i++) begin
      ay = W'($urandom_range(0, 15));
      ax = (2*W)'($urandom_range(0, 255));
      test_op(ax, ay, "rand");
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;
    test_reset();
    test_op(8'd37, 4'd5, "basic_37_5");
    test_back_to_back();
    test_op(8'd80, 4'd5, "ovf_80_5");
    test_op(8'd99, 4'd0, "dz_99_0");
    test_op(8'd255, 4'd1, "ovf_255_1");
    test_op(8'd15, 4'd1, "max_15_1");
    test_op(8'd239, 4'd15, "edge_239_15");
    test_op(8'd0, 4'd7, "zero_0_7");
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
